fib_seq_gen: RTL and testbench



---
 rtl/fib_seq_gen_if.sv | 29 ++
 rtl/fib_seq_gen.sv | 116 +++++++++++
 tb/tb_fib_seq_gen.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/fib_seq_gen_if.sv
// Command/result handshake bundle for fib_seq_gen.
// The master side issues commands and consumes result beats; the slave is the generator.
interface fib_seq_gen_if #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned NWIDTH = 16
);
    logic              in_valid;
    logic              in_ready;
    logic [NWIDTH-1:0] in_n;
    logic [WIDTH-1:0]  in_seed0;
    logic [WIDTH-1:0]  in_seed1;
    logic              in_stream;
    logic              out_valid;
    logic              out_ready;
    logic [WIDTH-1:0]  out_data;
    logic              out_last;
    logic              out_ovf;
    logic              busy;

    modport master (
        output in_valid, in_n, in_seed0, in_seed1, in_stream, out_ready,
        input  in_ready, out_valid, out_data, out_last, out_ovf, busy
    );

    modport slave (
        input  in_valid, in_n, in_seed0, in_seed1, in_stream, out_ready,
        output in_ready, out_valid, out_data, out_last, out_ovf, busy
    );
endinterface

// File: rtl/fib_seq_gen.sv
// Fibonacci-class sequence generator: F(k) = F(k-1) + F(k-2) from programmable seeds,
// returning F(n) only (final mode) or every term F(0)..F(n) (stream mode).
module fib_seq_gen #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned NWIDTH = 16
) (
    input  logic          clk,
    input  logic          reset,
    fib_seq_gen_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_OUT
    } state_t;

    state_t            state_q;
    logic [WIDTH-1:0]  a_q;
    logic [WIDTH-1:0]  b_q;
    logic [NWIDTH-1:0] k_q;
    logic [NWIDTH-1:0] n_q;
    logic              stream_q;
    logic              entry_q;
    logic              ovf_a_q;
    logic              ovf_b_q;
    logic              out_valid_q;
    logic [WIDTH-1:0]  out_data_q;
    logic              out_last_q;
    logic              out_ovf_q;

    logic [WIDTH:0]    sum_d;
    logic              k_done_d;

    always_comb begin
        sum_d    = {1'b0, a_q} + {1'b0, b_q};
        k_done_d = (k_q == n_q);
    end

    assign bus.in_ready  = (state_q == S_IDLE) && !reset;
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_last  = out_last_q;
    assign bus.out_ovf   = out_ovf_q;

    // ovf_a tracks wraps up to term a, ovf_b up to term b; the beat reports ovf_a so a
    // wrap in the look-ahead term b is not attributed to the term being presented.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            k_q         <= '0;
            n_q         <= '0;
            stream_q    <= 1'b0;
            entry_q     <= 1'b0;
            ovf_a_q     <= 1'b0;
            ovf_b_q     <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            out_ovf_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        n_q      <= bus.in_n;
                        stream_q <= bus.in_stream;
                        a_q      <= bus.in_seed0;
                        b_q      <= bus.in_seed1;
                        k_q      <= '0;
                        ovf_a_q  <= 1'b0;
                        ovf_b_q  <= 1'b0;
                        entry_q  <= 1'b1;
                        state_q  <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (entry_q) begin
                        entry_q <= 1'b0;
                    end else if (stream_q || k_done_d) begin
                        out_data_q  <= a_q;
                        out_last_q  <= k_done_d;
                        out_ovf_q   <= ovf_a_q;
                        out_valid_q <= 1'b1;
                        state_q     <= S_OUT;
                    end else begin
                        a_q     <= b_q;
                        b_q     <= sum_d[WIDTH-1:0];
                        k_q     <= k_q + NWIDTH'(1);
                        ovf_a_q <= ovf_b_q;
                        ovf_b_q <= ovf_b_q | sum_d[WIDTH];
                    end
                end
                S_OUT: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        if (out_last_q) begin
                            state_q <= S_IDLE;
                        end else begin
                            a_q     <= b_q;
                            b_q     <= sum_d[WIDTH-1:0];
                            k_q     <= k_q + NWIDTH'(1);
                            ovf_a_q <= ovf_b_q;
                            ovf_b_q <= ovf_b_q | sum_d[WIDTH];
                            state_q <= S_RUN;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fib_seq_gen.sv
// Self-checking bench for fib_seq_gen: directed and randomized commands compared against
// a term-by-term arithmetic model of the recurrence.
module tb_fib_seq_gen;
    localparam int W  = 16;
    localparam int NW = 8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    fib_seq_gen_if #(.WIDTH(W), .NWIDTH(NW)) bus ();

    fib_seq_gen #(.WIDTH(W), .NWIDTH(NW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    logic [W-1:0] exp_d[$];
    bit           exp_l[$];
    bit           exp_o[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Expected beats: full term list with true-sum carry detection, then the requested slice.
    function automatic void build_exp(input int n, input logic [W-1:0] s0,
                                      input logic [W-1:0] s1, input bit stream);
        logic [W-1:0] v[0:256];
        bit           cum[0:256];
        logic [W:0]   s;
        exp_d.delete();
        exp_l.delete();
        exp_o.delete();
        v[0] = s0;
        v[1] = s1;
        cum[0] = 1'b0;
        cum[1] = 1'b0;
        for (int k = 2; k <= n; k++) begin
            s      = {1'b0, v[k-1]} + {1'b0, v[k-2]};
            v[k]   = s[W-1:0];
            cum[k] = cum[k-1] | s[W];
        end
        for (int k = (stream ? 0 : n); k <= n; k++) begin
            exp_d.push_back(v[k]);
            exp_o.push_back(cum[k]);
            exp_l.push_back(k == n);
        end
    endfunction

    task automatic check_reset_values(input string tag);
        chk({tag, "_in_ready"},  32'(bus.in_ready), 0);
        chk({tag, "_out_valid"}, 32'(bus.out_valid), 0);
        chk({tag, "_out_data"},  32'(bus.out_data), 0);
        chk({tag, "_out_last"},  32'(bus.out_last), 0);
        chk({tag, "_out_ovf"},   32'(bus.out_ovf), 0);
        chk({tag, "_busy"},      32'(bus.busy), 0);
    endtask

    // Called at a negedge; returns at the negedge following the accept edge.
    task automatic accept_cmd(input int n, input logic [W-1:0] s0, input logic [W-1:0] s1,
                              input bit stream, input bit hold, output time t_acc);
        bit ok;
        ok = 1'b0;
        t_acc = 0;
        bus.in_n      = NW'(n);
        bus.in_seed0  = s0;
        bus.in_seed1  = s1;
        bus.in_stream = stream;
        bus.in_valid  = 1'b1;
        for (int i = 0; i < 200; i++) begin
            if (bus.in_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("accept_timeout", 32'(ok), 1);
        if (ok) begin
            @(posedge clk);
            t_acc = $time;
            @(negedge clk);
        end
        if (!hold) bus.in_valid = 1'b0;
    endtask

    task automatic collect(input bit rnd, input time t_acc, input int n, input bit stream,
                           output time t_hs, output logic [W-1:0] ld, output bit lo);
        time t_prev, t_seen;
        bit  first, done, r;
        t_hs   = 0;
        ld     = '0;
        lo     = 1'b0;
        t_prev = 0;
        for (int b = 0; b < exp_d.size(); b++) begin
            first = 1'b1;
            done  = 1'b0;
            for (int c = 0; c < 2000 && !done; c++) begin
                chk("in_ready_busy_excl", 32'(bus.in_ready & bus.busy), 0);
                r = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
                bus.out_ready = r;
                if (bus.out_valid) begin
                    if (first) begin
                        first  = 1'b0;
                        t_seen = $time;
                        if (b == 0)
                            chk("first_beat_latency", 32'(t_seen - t_acc), (stream ? 2 : n + 2) * 10 + 5);
                        else if (!rnd)
                            chk("beat_gap", 32'(t_seen - t_prev), 20);
                        t_prev = t_seen;
                    end
                    chk("data", 32'(bus.out_data), 32'(exp_d[b]));
                    chk("last", 32'(bus.out_last), 32'(exp_l[b]));
                    chk("ovf",  32'(bus.out_ovf),  32'(exp_o[b]));
                    ld = bus.out_data;
                    lo = bus.out_ovf;
                    if (r) begin
                        @(posedge clk);
                        t_hs = $time;
                        done = 1'b1;
                    end
                end
                @(negedge clk);
            end
            if (!done) begin
                chk("beat_timeout", 32'(done), 1);
                return;
            end
        end
        chk("post_out_valid", 32'(bus.out_valid), 0);
        chk("post_in_ready",  32'(bus.in_ready), 1);
    endtask

    task automatic run(input int n, input logic [W-1:0] s0, input logic [W-1:0] s1,
                       input bit stream, input bit rnd, output logic [W-1:0] ld, output bit lo);
        time t_acc, t_hs;
        build_exp(n, s0, s1, stream);
        accept_cmd(n, s0, s1, stream, 1'b0, t_acc);
        collect(rnd, t_acc, n, stream, t_hs, ld, lo);
    endtask

    task automatic pulse_reset_and_check(input string tag);
        int stray;
        reset = 1'b1;
        @(negedge clk);
        check_reset_values(tag);
        reset = 1'b0;
        @(negedge clk);
        chk({tag, "_release_in_ready"}, 32'(bus.in_ready), 1);
        chk({tag, "_release_busy"},     32'(bus.busy), 0);
        stray = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.out_valid) stray++;
            @(negedge clk);
        end
        chk({tag, "_stale_beats"}, 32'(stray), 0);
    endtask

    initial begin
        logic [W-1:0] ld;
        bit           lo;
        time          t_acc, t_hs;
        int           rn;
        bit           seen;

        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_n      = '0;
        bus.in_seed0  = '0;
        bus.in_seed1  = '0;
        bus.in_stream = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        reset = 1'b0;
        @(negedge clk);
        chk("reset_release_in_ready", 32'(bus.in_ready), 1);

        run(10, 16'd0, 16'd1, 1'b0, 1'b0, ld, lo);
        chk("fib10", 32'(ld), 55);
        chk("fib10_ovf", 32'(lo), 0);
        run(0, 16'd0, 16'd1, 1'b0, 1'b0, ld, lo);
        chk("fib0", 32'(ld), 0);
        run(1, 16'd0, 16'd1, 1'b0, 1'b0, ld, lo);
        chk("fib1", 32'(ld), 1);
        run(1, 16'd0, 16'd1, 1'b1, 1'b0, ld, lo);
        run(6, 16'd2, 16'd1, 1'b0, 1'b0, ld, lo);
        chk("lucas6", 32'(ld), 18);

        run(5, 16'd0, 16'd1, 1'b1, 1'b0, ld, lo);
        chk("stream5_last", 32'(ld), 5);
        run(5, 16'd0, 16'd1, 1'b1, 1'b1, ld, lo);

        run(24, 16'd0, 16'd1, 1'b0, 1'b0, ld, lo);
        chk("fib24", 32'(ld), 46368);
        chk("fib24_ovf", 32'(lo), 0);
        run(25, 16'd0, 16'd1, 1'b0, 1'b0, ld, lo);
        chk("fib25", 32'(ld), 9489);
        chk("fib25_ovf", 32'(lo), 1);
        run(26, 16'd0, 16'd1, 1'b1, 1'b0, ld, lo);
        chk("stream26_ovf", 32'(lo), 1);

        run(255, 16'd0, 16'd1, 1'b0, 1'b0, ld, lo);
        run(255, 16'd3, 16'd7, 1'b1, 1'b1, ld, lo);

        for (int i = 0; i < 10; i++) begin
            rn = int'($urandom_range(0, 40));
            run(rn, W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ld, lo);
        end

        // Second command held on the input while the first is in flight.
        build_exp(4, 16'd0, 16'd1, 1'b0);
        accept_cmd(4, 16'd0, 16'd1, 1'b0, 1'b1, t_acc);
        bus.in_n     = NW'(3);
        bus.in_seed0 = 16'd2;
        bus.in_seed1 = 16'd1;
        collect(1'b1, t_acc, 4, 1'b0, t_hs, ld, lo);
        chk("busy_first_result", 32'(ld), 3);
        @(negedge clk);
        chk("busy_second_accepted_busy", 32'(bus.busy), 1);
        chk("busy_second_accepted_ready", 32'(bus.in_ready), 0);
        bus.in_valid = 1'b0;
        build_exp(3, 16'd2, 16'd1, 1'b0);
        collect(1'b0, t_hs + 10, 3, 1'b0, t_hs, ld, lo);
        chk("busy_second_result", 32'(ld), 4);

        // Reset while iterating.
        accept_cmd(20, 16'd0, 16'd1, 1'b0, 1'b0, t_acc);
        repeat (3) @(negedge clk);
        pulse_reset_and_check("rst_run");
        run(7, 16'd0, 16'd1, 1'b0, 1'b0, ld, lo);
        chk("rst_run_fib7", 32'(ld), 13);

        // Reset while a beat is stalled.
        bus.out_ready = 1'b0;
        accept_cmd(5, 16'd0, 16'd1, 1'b1, 1'b0, t_acc);
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (bus.out_valid) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("rst_out_reached", 32'(seen), 1);
        repeat (2) @(negedge clk);
        pulse_reset_and_check("rst_out");
        run(7, 16'd0, 16'd1, 1'b0, 1'b0, ld, lo);
        chk("rst_out_fib7", 32'(ld), 13);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
